// File: rtl/tl_pkg.sv
// Light encodings and light/sequence-state types shared by the controller and the sensor.
// Latency: none, declarations only.
// Backpressure: none.
package tl_pkg;

  typedef logic [1:0] light_t;

  localparam light_t GREEN   = 2'b00;
  localparam light_t YELLOW  = 2'b01;
  localparam light_t RED     = 2'b10;
  localparam light_t ILLEGAL = 2'b11;

  // Last legal light value seen by a lane's sequence checker.
  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_RED    = 2'b10
  } seq_state_t;

endpackage

// File: rtl/tl_lane.sv
// One street: car queue with departure timer, overflow flag and light-sequence checker.
// Latency: q, ovf and err_seq update one edge after the sampled inputs.
// Backpressure: none; an arrival into a full queue is dropped and latched in ovf.
module tl_lane
  import tl_pkg::*;
#(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          car,
  input  logic [1:0]    light,
  output logic [QW-1:0] q,
  output logic          ovf,
  output logic          err_seq
);

  localparam int TW = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DEPART_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          counting;
  logic          dep;
  logic          full;
  seq_state_t    state_q;
  seq_state_t    state_d;
  logic          bad_seq;

  // Cars only leave on green, and only when someone is waiting.
  assign counting = (light == GREEN) && (q != '0);
  assign dep      = counting && (timer == TMAX);
  assign full     = (q == {QW{1'b1}});

  // Departure timer: counts green cycles per car, clears whenever not counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!counting || dep) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Queue counter: arrival and departure in the same cycle cancel; full queue drops arrivals.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (car && !dep) begin
      if (full) begin
        ovf <= 1'b1;
      end else begin
        q <= q + QW'(1);
      end
    end else if (dep && !car) begin
      q <= q - QW'(1);
    end
  end

  // Sequence-checker state register and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RED;
      err_seq <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bad_seq) begin
        err_seq <= 1'b1;
      end
    end
  end

  // Next state follows the light; illegal code keeps the old state and flags an error.
  always_comb begin
    state_d = state_q;
    bad_seq = 1'b0;
    case (light)
      GREEN: begin
        state_d = ST_GREEN;
        bad_seq = (state_q == ST_YELLOW);
      end
      YELLOW: begin
        state_d = ST_YELLOW;
        bad_seq = (state_q == ST_RED);
      end
      RED: begin
        state_d = ST_RED;
        bad_seq = (state_q == ST_GREEN);
      end
      default: begin
        bad_seq = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tl_traffic_sensor.sv
// Traffic model for the light controller: two street queues driving Ta/Tb plus light monitors.
// Latency: queues and flags one edge; Ta/Tb decoded combinationally from the queue registers.
// Backpressure: none; overflowing arrivals are dropped and flagged sticky.
module tl_traffic_sensor
  import tl_pkg::*;
#(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          car_a,
  input  logic          car_b,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          ovf_a,
  output logic          ovf_b,
  output logic          err_seq,
  output logic          err_conf
);

  logic err_seq_a;
  logic err_seq_b;
  logic conflict;

  tl_lane #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_lane_a (
    .clk     (clk),
    .reset_n (reset_n),
    .car     (car_a),
    .light   (La),
    .q       (qa),
    .ovf     (ovf_a),
    .err_seq (err_seq_a)
  );

  tl_lane #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_lane_b (
    .clk     (clk),
    .reset_n (reset_n),
    .car     (car_b),
    .light   (Lb),
    .q       (qb),
    .ovf     (ovf_b),
    .err_seq (err_seq_b)
  );

  assign Ta      = (qa != '0);
  assign Tb      = (qb != '0);
  assign err_seq = err_seq_a | err_seq_b;

  // Illegal codes are reported by the sequence checkers, not counted as a conflict.
  assign conflict = (La != RED) && (Lb != RED) && (La != ILLEGAL) && (Lb != ILLEGAL);

  // Sticky conflicting-greens flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_conf <= 1'b0;
    end else if (conflict) begin
      err_conf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_traffic_sensor.sv
// Directed bench for tl_traffic_sensor with QW=4, DEPART_CYCLES=2.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_tl_traffic_sensor;
  import tl_pkg::*;

  localparam int QW = 4;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          car_a;
  logic          car_b;
  logic [1:0]    La;
  logic [1:0]    Lb;
  logic          Ta;
  logic          Tb;
  logic [QW-1:0] qa;
  logic [QW-1:0] qb;
  logic          ovf_a;
  logic          ovf_b;
  logic          err_seq;
  logic          err_conf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ca;
    logic        cb;
    logic [1:0]  la;
    logic [1:0]  lb;
    logic [13:0] exp;  // {qa, qb, Ta, Tb, ovf_a, ovf_b, err_seq, err_conf}
  } vec_t;

  vec_t vecs[16];

  tl_traffic_sensor #(.QW(QW), .DEPART_CYCLES(DC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .car_a    (car_a),
    .car_b    (car_b),
    .La       (La),
    .Lb       (Lb),
    .Ta       (Ta),
    .Tb       (Tb),
    .qa       (qa),
    .qb       (qb),
    .ovf_a    (ovf_a),
    .ovf_b    (ovf_b),
    .err_seq  (err_seq),
    .err_conf (err_conf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ca, input logic cb, input logic [1:0] la,
                              input logic [1:0] lb, input int eqa, input int eqb,
                              input logic eta, input logic etb);
    vec_t v;
    v.ca  = ca;
    v.cb  = cb;
    v.la  = la;
    v.lb  = lb;
    v.exp = {eqa[3:0], eqb[3:0], eta, etb, 4'b0000};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    car_a   = 1'b0;
    car_b   = 1'b0;
    La      = RED;
    Lb      = RED;
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [13:0] outs();
    return {qa, qb, Ta, Tb, ovf_a, ovf_b, err_seq, err_conf};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0]  = mk(1, 0, RED,    RED, 1, 0, 1, 0);
    vecs[1]  = mk(1, 0, RED,    RED, 2, 0, 1, 0);
    vecs[2]  = mk(1, 0, RED,    RED, 3, 0, 1, 0);
    vecs[3]  = mk(0, 1, RED,    RED, 3, 1, 1, 1);
    vecs[4]  = mk(0, 0, GREEN,  RED, 3, 1, 1, 1);
    vecs[5]  = mk(0, 0, GREEN,  RED, 2, 1, 1, 1);
    vecs[6]  = mk(0, 0, GREEN,  RED, 2, 1, 1, 1);
    vecs[7]  = mk(0, 0, GREEN,  RED, 1, 1, 1, 1);
    vecs[8]  = mk(0, 0, YELLOW, RED, 1, 1, 1, 1);
    vecs[9]  = mk(0, 0, YELLOW, RED, 1, 1, 1, 1);
    vecs[10] = mk(0, 0, RED,    RED, 1, 1, 1, 1);
    vecs[11] = mk(0, 0, GREEN,  RED, 1, 1, 1, 1);
    vecs[12] = mk(1, 0, GREEN,  RED, 1, 1, 1, 1);
    vecs[13] = mk(0, 0, GREEN,  RED, 1, 1, 1, 1);
    vecs[14] = mk(0, 0, GREEN,  RED, 0, 1, 0, 1);
    vecs[15] = mk(0, 0, GREEN,  RED, 0, 1, 0, 1);

    // Asynchronous reset in the middle of operation
    do_reset();
    chk("reset_state", 32'(outs()), 32'h0);
    car_a = 1'b1;
    repeat (3) tick();
    car_a = 1'b0;
    chk("pre_reset_qa", 32'(qa), 32'd3);
    chk("pre_reset_ta", 32'(Ta), 32'd1);
    Lb = ILLEGAL;
    tick();
    chk("pre_reset_err_seq", 32'(err_seq), 32'd1);
    Lb = RED;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'h0);
    tick();
    reset_n = 1'b1;

    // Table: fill, drain at 2 cycles/car, hold on yellow/red, simultaneous arrive+depart
    for (int i = 0; i < 16; i++) begin
      car_a = vecs[i].ca;
      car_b = vecs[i].cb;
      La    = vecs[i].la;
      Lb    = vecs[i].lb;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    car_a = 1'b0;
    car_b = 1'b0;

    // Sequence error: G, G, R
    La = GREEN;
    tick();
    chk("seq_gg_ok", 32'(err_seq), 32'd0);
    La = RED;
    tick();
    chk("seq_g_to_r", 32'(err_seq), 32'd1);
    tick();
    chk("seq_sticky", 32'(err_seq), 32'd1);

    // Legal cycle R, G, Y, R
    do_reset();
    La = RED;    tick();
    La = GREEN;  tick();
    La = YELLOW; tick();
    La = RED;    tick();
    chk("seq_legal_cycle", 32'({err_seq, err_conf}), 32'd0);
    La = ILLEGAL;
    tick();
    chk("seq_illegal_code", 32'(err_seq), 32'd1);

    // Conflict: A green with B yellow, then sticky
    do_reset();
    La = GREEN;
    Lb = YELLOW;
    tick();
    chk("conf_set", 32'(err_conf), 32'd1);
    La = YELLOW;
    Lb = RED;
    tick();
    chk("conf_sticky", 32'(err_conf), 32'd1);

    do_reset();
    La = RED;
    Lb = GREEN;
    tick();
    chk("no_conf_r_g", 32'({err_seq, err_conf}), 32'd0);

    // Overflow: 16 arrivals on red into a 15-deep queue
    do_reset();
    car_a = 1'b1;
    repeat (15) tick();
    chk("full_no_ovf", 32'({qa, ovf_a}), 32'({4'd15, 1'b0}));
    tick();
    car_a = 1'b0;
    chk("ovf_qa_hold", 32'(qa), 32'd15);
    chk("ovf_a_set", 32'({ovf_a, ovf_b}), 32'b10);
    tick();
    chk("ovf_sticky", 32'(ovf_a), 32'd1);

    // Closed loop: B holds 2 cars, A empty; A green -> yellow -> red, then B green
    do_reset();
    car_b = 1'b1;
    repeat (2) tick();
    car_b = 1'b0;
    chk("loop_qb_init", 32'({qb, Tb, Ta}), 32'({4'd2, 1'b1, 1'b0}));
    La = GREEN;  repeat (2) tick();
    La = YELLOW; tick();
    La = RED;
    Lb = GREEN;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!Tb) begin
        n = k;
        break;
      end
    end
    chk("loop_tb_drop_edges", 32'(n), 32'(2 * DC));
    chk("loop_no_flags", 32'({ovf_a, ovf_b, err_seq, err_conf}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_traffic_sensor.md
# tl_traffic_sensor

Traffic-side counterpart of the traffic light controller: it consumes the controller's light outputs La/Lb and produces the controller's traffic-sensor inputs Ta/Tb. Per street, it keeps a queue of waiting cars, drains the queue while that street is green, and asserts the sensor while cars are waiting. It also monitors the light outputs and raises sticky flags for illegal light sequences and conflicting greens. It sits beside the controller in the intersection top level, closing the loop for system-level simulation and on-board demos.

## Interface
- QW, 4, queue counter width; queue range 0..2^QW-1
- DEPART_CYCLES, 2, green cycles per departing car; legal range is at least 1
- clk  in  1  system clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- car_a  in  1  car arrival on street A, one car per cycle while high
- car_b  in  1  car arrival on street B
- La  in  2  street A light from the controller
- Lb  in  2  street B light from the controller
- Ta  out  1  traffic present on A, equal to (qa != 0)
- Tb  out  1  traffic present on B, equal to (qb != 0)
- qa  out  QW  cars queued on A
- qb  out  QW  cars queued on B
- ovf_a  out  1  sticky: arrival dropped on A while the queue was full
- ovf_b  out  1  sticky: arrival dropped on B while the queue was full
- err_seq  out  1  sticky: illegal light transition or illegal code on La or Lb
- err_conf  out  1  sticky: La and Lb both non-RED in the same cycle

## Operation
- Light encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10. The code 2'b11 is illegal.
- Per-street queue update on each edge, where arr = car_x and dep = departure event:
  - arr only: q+1.
  - dep only: q-1.
  - Both: q unchanged.
  - Neither: q unchanged.
- Queue full (q = 2^QW-1) with arr and no dep:
  - q holds.
  - ovf_x is set and stays set until reset.
- Departure timer per street (range 0..DEPART_CYCLES-1):
  - Counts only while L_x = GREEN and q != 0.
  - A departure occurs on the edge where the timer equals DEPART_CYCLES-1 and the counting condition holds; the timer then returns to 0.
  - The timer clears to 0 whenever L_x is not GREEN or q = 0.
  - The timer never wraps on its own.
- Cars do not depart on YELLOW or RED.
- Sequence checker per street:
  - A state register holds the previous light value. Its states are GREEN, YELLOW and RED; the reset state is RED.
  - Legal transitions: G->G, G->Y, Y->Y, Y->R, R->R, R->G.
  - Any other transition (G->R, Y->G, R->Y) sets err_seq.
  - Code 2'b11 sets err_seq; the state register keeps its old value.
  - Otherwise the state register loads the sampled light value.
- Conflict check: err_conf is set on any edge where La != RED and Lb != RED, with both codes legal.
- err_seq and err_conf are each the OR over both streets. Once set, they are cleared only by reset.

## Timing
- Reset values: qa=qb=0, Ta=Tb=0, all flags 0, both timers 0, both sequence states RED.
- Reset is asynchronous: asserting reset_n mid-operation clears all state immediately, without waiting for a clock edge.
- Inputs are sampled on the rising edge. Latency for qa/qb and all flags is one edge.
- Ta/Tb are decoded combinationally from the qa/qb registers, so they change only after clock edges and are glitch-free relative to the controller's sampling edge.
- Example with DEPART_CYCLES=2, A green, qa=3: qa goes 3->2 on the 2nd green edge, 2->1 on the 4th and 1->0 on the 6th.

## Structure
- Package tl_pkg holds:
  - The GREEN/YELLOW/RED/ILLEGAL light constants.
  - A 2-bit light_t typedef.
  - This package is shared with the controller.
- Sub-module tl_lane, one instance per street, contains:
  - The queue counter with saturation and the ovf flag.
  - The departure timer.
  - The sequence-checker FSM, with a per-lane err_seq output.
- The top level instantiates two tl_lane instances and adds:
  - The conflict check.
  - The ORing of the two per-lane err_seq outputs.

## Test plan
- Reset: drive La=Lb=RED, pulse car_a for 3 cycles, then assert reset_n=0 between clock edges.
  - Before reset: qa=3 and Ta=1.
  - At reset: qa=0, Ta=0 and all flags 0 immediately, without a clock edge.
- Drain: qa=3, DEPART_CYCLES=2, La=GREEN, Lb=RED.
  - qa reaches 0 after 6 edges.
  - Ta falls on the same edge qa reaches 0.
  - qa does not change while La=YELLOW.
- Simultaneous events and overflow: qa=1, car_a=1, La=GREEN on the departure edge.
  - qa stays 1.
  - With QW=4, 16 arrivals on RED give qa=15 and ovf_a=1.
- Sequence error: La sequence G, G, R.
  - err_seq=1 from the third edge onward.
  - R, G, Y, R raises no error.
  - La=2'b11 for one cycle sets err_seq.
- Conflict: La=GREEN and Lb=YELLOW in the same cycle.
  - err_conf=1 and it stays set.
  - La=RED with Lb=GREEN raises no error.
- Closed loop with the controller:
  - Initial state: B queue=2, A empty.
  - Expected result: Tb drops to 0 after B has been green for 2×DEPART_CYCLES edges, and no error flag is ever set.
